// File: rtl/sa_pkg.sv
// sa_pkg: shared definitions for the systolic-array operand feeder.
//   sa_state_e  : feeder FSM state encoding
//   SEL_X/SEL_W : wr_sel values selecting the X or W operand buffer
//   DRAIN_SLACK : extra cycles added to the M+N+K drain watchdog budget
package sa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } sa_state_e;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_W = 1'b1;

  localparam int DRAIN_SLACK = 4;

endpackage

// File: rtl/sa_operand_buf.sv
// sa_operand_buf: single-write-port operand store with a combinational
// full-vector read. Element for (lane l, index i) lives at
// l*LANE_STRIDE + i*IDX_STRIDE, so one module serves both the row-major
// X buffer (lane = row m, index = column n) and the W buffer
// (lane = column k, index = row n).
// Ports:
//   clk      in  clock (storage is not reset)
//   wr_en    in  write strobe
//   wr_addr  in  element address; addresses >= DEPTH are dropped
//   wr_data  in  element value
//   rd_idx   in  reduction index selecting the vector
//   rd_vec   out LANES elements, lane l in bits [l*WIDTH +: WIDTH]
module sa_operand_buf #(
  parameter int DEPTH       = 15,
  parameter int WIDTH       = 32,
  parameter int LANES       = 5,
  parameter int LANE_STRIDE = 3,
  parameter int IDX_STRIDE  = 1,
  parameter int AW          = 4,
  parameter int IW          = 2
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [IW-1:0]          rd_idx,
  output logic [LANES*WIDTH-1:0] rd_vec
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_vec = '0;
    for (int l = 0; l < LANES; l++) begin
      rd_vec[l*WIDTH +: WIDTH] = mem[AW'(l*LANE_STRIDE) + AW'(IDX_STRIDE) * AW'(rd_idx)];
    end
  end

endmodule

// File: rtl/sa_feeder.sv
// sa_feeder: buffers one X (M x N) and one W (N x K) operand matrix and
// sequences a matmul pass into the downstream systolic array: a one-cycle
// array clear, N unskewed operand vectors, then a wait for sa_done before
// pulsing done_pulse.
// Optional build macro SA_FEEDER_TIMEOUT_EN adds a drain watchdog that
// pulses err and abandons the pass when sa_done does not arrive within
// M+N+K+DRAIN_SLACK drain cycles; without it err is tied low.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_addr/wr_data  buffer write port (IDLE only)
//                X(m,n) at m*N+n, W(n,k) at n*K+k
//   start       begin a pass (ignored unless IDLE)
//   busy        high from accepted start until back in IDLE
//   done_pulse  one-cycle result-valid pulse
//   err         one-cycle drain-timeout pulse
//   sa_rst_n    active-low clear to the array
//   sa_x        lane m = X(m,n)
//   sa_w        lane k = W(n,k)
//   sa_done     completion from the array (only honoured in DRAIN)
module sa_feeder
  import sa_pkg::*;
#(
  parameter int  M          = 5,
  parameter int  N          = 3,
  parameter int  K          = 4,
  parameter int  DATA_WIDTH = 32,
  localparam int AW         = $clog2((M*N > N*K) ? M*N : N*K)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done_pulse,
  output logic                    err,
  output logic                    sa_rst_n,
  output logic [DATA_WIDTH*M-1:0] sa_x,
  output logic [DATA_WIDTH*K-1:0] sa_w,
  input  logic                    sa_done
);

  localparam int NW = $clog2(N+1);

  sa_state_e               state_q, state_d;
  logic [NW-1:0]           n_q, n_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    sa_rst_n_q, sa_rst_n_d;
  logic [DATA_WIDTH*M-1:0] sa_x_q, sa_x_d, x_vec;
  logic [DATA_WIDTH*K-1:0] sa_w_q, sa_w_d, w_vec;
  logic                    wr_ok;

`ifdef SA_FEEDER_TIMEOUT_EN
  localparam int WD_LIMIT = M + N + K + DRAIN_SLACK;
  localparam int WDW      = $clog2(WD_LIMIT+1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`endif

  // Writes only land while idle; a write coincident with start still lands
  // and is read back during STREAM two cycles later.
  assign wr_ok = wr_en && (state_q == ST_IDLE);

  sa_operand_buf #(
    .DEPTH(M*N), .WIDTH(DATA_WIDTH), .LANES(M),
    .LANE_STRIDE(N), .IDX_STRIDE(1), .AW(AW), .IW(NW)
  ) u_xbuf (
    .clk(clk), .wr_en(wr_ok && (wr_sel == SEL_X)), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_idx(n_q), .rd_vec(x_vec)
  );

  sa_operand_buf #(
    .DEPTH(N*K), .WIDTH(DATA_WIDTH), .LANES(K),
    .LANE_STRIDE(1), .IDX_STRIDE(K), .AW(AW), .IW(NW)
  ) u_wbuf (
    .clk(clk), .wr_en(wr_ok && (wr_sel == SEL_W)), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_idx(n_q), .rd_vec(w_vec)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sa_rst_n_d = 1'b1;
    sa_x_d     = '0;
    sa_w_d     = '0;
`ifdef SA_FEEDER_TIMEOUT_EN
    wd_d       = wd_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        sa_rst_n_d = 1'b0;
        n_d        = '0;
        state_d    = ST_STREAM;
`ifdef SA_FEEDER_TIMEOUT_EN
        wd_d       = '0;
`endif
      end
      ST_STREAM: begin
        sa_x_d = x_vec;
        sa_w_d = w_vec;
        // Leave on the last column so the counter never wraps in STREAM.
        if (n_q == NW'(N-1)) begin
          n_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      ST_DRAIN: begin
        if (sa_done) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
`ifdef SA_FEEDER_TIMEOUT_EN
        // Timeout reuses DONE as the one-cycle busy tail, but with err
        // raised instead of done_pulse.
        else if (wd_q == WDW'(WD_LIMIT-1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
`endif
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sa_rst_n_q <= 1'b0;
      sa_x_q     <= '0;
      sa_w_q     <= '0;
`ifdef SA_FEEDER_TIMEOUT_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sa_rst_n_q <= sa_rst_n_d;
      sa_x_q     <= sa_x_d;
      sa_w_q     <= sa_w_d;
`ifdef SA_FEEDER_TIMEOUT_EN
      wd_q       <= wd_d;
      err_q      <= err_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign sa_rst_n   = sa_rst_n_q;
  assign sa_x       = sa_x_q;
  assign sa_w       = sa_w_q;
`ifdef SA_FEEDER_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_sa_feeder.sv
module tb_sa_feeder;

  localparam int M  = 5;
  localparam int N  = 3;
  localparam int K  = 4;
  localparam int DW = 32;
  localparam int AW = $clog2((M*N > N*K) ? M*N : N*K);
  localparam int WD = M + N + K + 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic            wr_sel;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            start;
  logic            busy;
  logic            done_pulse;
  logic            err;
  logic            sa_rst_n;
  logic [DW*M-1:0] sa_x;
  logic [DW*K-1:0] sa_w;
  logic            sa_done;

  sa_feeder dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy),
    .done_pulse(done_pulse), .err(err), .sa_rst_n(sa_rst_n),
    .sa_x(sa_x), .sa_w(sa_w), .sa_done(sa_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference matrices as loaded through the write port.
  int unsigned xm [M][N];
  int unsigned wm [N][K];

  typedef struct packed {
    int                        t0;
    bit                        to;
    logic [N-1:0][DW*M-1:0]    xv;
    logic [N-1:0][DW*K-1:0]    wv;
  } pass_t;

  pass_t exp_q[$];

  function automatic pass_t mk_rec(input int t0, input bit to);
    pass_t r;
    r.t0 = t0;
    r.to = to;
    r.xv = '0;
    r.wv = '0;
    for (int b = 0; b < N; b++) begin
      for (int m = 0; m < M; m++) r.xv[b][m*DW +: DW] = xm[m][b];
      for (int k = 0; k < K; k++) r.wv[b][k*DW +: DW] = wm[b][k];
    end
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int    phase     = 0;
  int    beat      = 0;
  int    exp_pulse = -1;
  int    rel_cyc   = -1;
  bit    prev_low  = 1'b1;
  pass_t cur;

  always @(negedge clk) begin
    bit exp_b, exp_done, exp_err;
    if (!rst_n) begin
      chk("reset_state", {busy, done_pulse, err, sa_rst_n, sa_x, sa_w}, '0);
      phase    = 0;
      prev_low = 1'b1;
    end else begin
      if (prev_low) begin
        rel_cyc  = cyc;
        prev_low = 1'b0;
      end
      case (phase)
        0: begin
          if (cyc == rel_cyc) begin
            chk("sa_rst_n_release", sa_rst_n, 1'b0);
          end else if (!sa_rst_n) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_clear", 1'b1, 1'b0);
            end else begin
              cur = exp_q.pop_front();
              chk("clear_time", cyc, cur.t0 + 1);
              chk("clear_data", {busy, done_pulse, sa_x, sa_w}, {1'b1, 1'b0, {(DW*(M+K)){1'b0}}});
              phase     = 1;
              beat      = 0;
              exp_pulse = -1;
            end
          end else begin
            exp_b = (exp_q.size() > 0) && (cyc == exp_q[0].t0);
            chk("idle_busy", busy, exp_b);
            chk("idle_out", {done_pulse, err, sa_x, sa_w}, '0);
          end
        end
        1: begin
          chk("stream_x", sa_x, cur.xv[beat]);
          chk("stream_w", sa_w, cur.wv[beat]);
          chk("stream_ctl", {busy, sa_rst_n, done_pulse, err}, 4'b1100);
          if (exp_pulse < 0 && cyc >= cur.t0 + N + 1 && sa_done) exp_pulse = cyc + 1;
          beat++;
          if (beat == N) phase = 2;
        end
        default: begin
          exp_done = (cyc == exp_pulse);
          exp_err  = 1'b0;
`ifdef SA_FEEDER_TIMEOUT_EN
          exp_err  = (exp_pulse < 0) && (cyc == cur.t0 + N + 1 + WD);
`endif
          chk("drain_out", {busy, sa_rst_n, sa_x, sa_w}, {2'b11, {(DW*(M+K)){1'b0}}});
          chk("done_pulse", done_pulse, exp_done);
          chk("err", err, exp_err);
          if (exp_done || exp_err || done_pulse || err) begin
            phase = 0;
          end else if (cyc > cur.t0 + 100) begin
            chk("drain_stall", 1'b1, 1'b0);
            phase = 0;
          end else if (exp_pulse < 0 && sa_done) begin
            exp_pulse = cyc + 1;
          end
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int addr, input int unsigned data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = data;
    if (sel == 1'b0) xm[addr / N][addr % N] = data;
    else             wm[addr / K][addr % K] = data;
    tick();
    wr_en = 1'b0;
  endtask

  // d: cycle offset from t0 at which the array model raises sa_done.
  task automatic run_pass(input int d, input bit junk, input bit mid_wr,
                          input bit wr_same, input bit start_in_done, input bit to);
    int          t0;
    int          a;
    int unsigned v;
    if (wr_same) begin
      a       = $urandom_range(0, M*N-1);
      v       = $urandom;
      wr_en   = 1'b1;
      wr_sel  = 1'b0;
      wr_addr = AW'(a);
      wr_data = v;
      xm[a / N][a % N] = v;
    end
    t0 = cyc + 1;
    exp_q.push_back(mk_rec(t0, to));
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    while (cyc < t0 + d) begin
      sa_done = 1'b0;
      if (junk && cyc <= t0 + 3) sa_done = 1'($urandom_range(0, 1));
      if (mid_wr && cyc == t0 + 2) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = 32'd999;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
    end
    sa_done = !to;
    tick();
    sa_done = 1'b0;
    if (start_in_done) start = 1'b1;
    tick();
  endtask

  task automatic run_abort();
    int t0;
    t0 = cyc + 1;
    exp_q.push_back(mk_rec(t0, 1'b0));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    sa_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) wr(1'b0, m*N + n, 10*m + n);
    for (int n = 0; n < N; n++)
      for (int k = 0; k < K; k++) wr(1'b1, n*K + k, 100*n + k);

    run_pass(14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_pass(9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_pass(6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_abort();
    run_pass(4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_pass(8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_pass(5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SA_FEEDER_TIMEOUT_EN
    run_pass(WD + N + 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 1) == 0) wr(1'b0, $urandom_range(0, M*N-1), $urandom);
        else                           wr(1'b1, $urandom_range(0, N*K-1), $urandom);
      end
      run_pass($urandom_range(4, 19), 1'($urandom_range(0, 1)), 1'b0,
               1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/sa_feeder.md
Name: sa_feeder

Overview:
- Operand staging and sequencing stage directly upstream of the systolic_array matmul block.
- Buffers one X matrix (M x N) and one W matrix (N x K) written over a simple memory-style port.
- On start, drives a one-cycle clear (sa_rst_n low) into the array, then streams N unskewed column/row vectors on sa_x/sa_w. The array applies its own skew.
- Waits for sa_done from the array, then pulses done_pulse so the downstream result collector can sample Y.

Parameters:
M, 5, rows of X / array height
N, 3, reduction length (columns of X, rows of W)
K, 4, columns of W / array width
DATA_WIDTH, 32, element width
AW, $clog2(max(M*N,N*K)), buffer address width (localparam)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_sel  in  1  0 = X buffer, 1 = W buffer
wr_addr  in  AW  X(m,n) at m*N+n; W(n,k) at n*K+k
wr_data  in  DATA_WIDTH  element value
start  in  1  begin one matmul pass
busy  out  1  high from accepted start until return to IDLE
done_pulse  out  1  one-cycle pulse: array result valid
err  out  1  one-cycle pulse: drain timeout (optional feature only)
sa_rst_n  out  1  active-low clear to the array
sa_x  out  DATA_WIDTH*M  lane m = X(m,n)
sa_w  out  DATA_WIDTH*K  lane k = W(n,k)
sa_done  in  1  done from the array

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done_pulse, err, sa_x, sa_w = 0.
  - sa_rst_n=0.
  - Buffers are not reset.
- After reset release: sa_rst_n=1 from the first clk edge.
- All outputs are registered.
- FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 is accepted at edge t0; state becomes CLEAR and busy=1 from t0.
  - wr_en writes are accepted only in IDLE; writes in any other state are dropped.
  - A write and start in the same cycle: the write lands, and streaming sees the new value.
- CLEAR (one cycle, edge t0+1): sa_rst_n=0 and sa_x/sa_w=0.
- STREAM (N cycles, edges t0+2 .. t0+N+1):
  - Column counter n runs 0..N-1.
  - sa_x lane m = X(m,n); sa_w lane k = W(n,k).
  - sa_rst_n=1.
- DRAIN:
  - sa_x/sa_w held at 0.
  - Waits for sa_done=1. sa_done is ignored in every other state.
- DONE (one cycle): done_pulse=1, busy=1.
- Next cycle: IDLE with busy=0. start in DONE is ignored.
- start while busy: ignored, with no queuing.
- Counter n width: $clog2(N+1). The counter never wraps inside STREAM.
- Reset asserted mid-pass: immediate return to IDLE with all outputs at reset values. Buffer contents are retained.

Optional Feature:
- Macro: SA_FEEDER_TIMEOUT_EN.
- Defined:
  - DRAIN watchdog counts cycles spent in DRAIN.
  - If sa_done is not seen within M+N+K+4 cycles, pulse err for one cycle and go to IDLE with busy=0. done_pulse stays 0.
- Undefined:
  - No watchdog; DRAIN waits indefinitely.
  - err is tied to 0.

Decomposition:
- Shared package sa_pkg:
  - State encoding constants ST_IDLE, ST_CLEAR, ST_STREAM, ST_DRAIN, ST_DONE.
  - SEL_X/SEL_W constants.
  - DRAIN_SLACK=4.
- Sub-module sa_operand_buf (parameterised depth, width, and read-vector lanes): one instance for X, one for W.
  - Single write port.
  - Combinational read of a full lane vector for a given n.
- The top level holds the FSM, counters, and output registers.

Test Plan (M=5, N=3, K=4, DATA_WIDTH=32):
1. Load X(m,n)=10m+n and W(n,k)=100n+k, then start at t0:
   - t0+1: sa_rst_n=0.
   - t0+2: sa_x={40,30,20,10,0}, sa_w={3,2,1,0}.
   - t0+3: sa_x={41,31,21,11,1}, sa_w={103,102,101,100}.
   - t0+4: rows n=2.
   - t0+5 onward: sa_x=0, sa_w=0.
2. Array model asserts sa_done at t0+14 -> done_pulse=1 at t0+15, busy=0 at t0+16. Random sa_done before DRAIN has no effect.
3. start and wr_en (X addr 0 <- 999) during STREAM -> no restart. A second pass still shows X(0,0)=0.
4. rst_n low at t0+3 -> sa_x=0, sa_w=0, busy=0, sa_rst_n=0 asynchronously. A new start after release streams correct data.
5. start asserted during the DONE cycle -> ignored. start one cycle later -> accepted.
6. With SA_FEEDER_TIMEOUT_EN and sa_done tied 0 -> err pulse 16 cycles after DRAIN entry, busy=0 next cycle, done_pulse never asserted.
